// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// State/owner encodings plus a helper that sizes counters from their maximum value.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } owner_e;

  localparam int          DEF_MAX_CPU_STREAK = 4;
  localparam int          DEF_TIMEOUT_CYCLES = 256;
  localparam logic [31:0] DEF_ERR_DATA       = 32'hDEAD_BEEF;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU memory stage and an aux loader.
// CPU has fixed priority with a starvation guard for aux; hung accesses are aborted by a timeout.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          MAX_CPU_STREAK = DEF_MAX_CPU_STREAK,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic [31:0] aux_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int STREAK_W = cnt_width(MAX_CPU_STREAK);
  localparam int TMO_W    = cnt_width(TIMEOUT_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e              state_r;
  state_e              state_next_s;
  owner_e              owner_r;
  logic [STREAK_W-1:0] streak_r;
  logic [TMO_W-1:0]    tmo_r;
  logic                grant_aux_s;
  logic                timeout_s;
  logic [31:0]         resp_data_s;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [31:0]         mem_addr_r;
  logic [31:0]         mem_wdata_r;
  logic                cpu_ready_r;
  logic                aux_ready_r;
  logic [31:0]         cpu_rdata_r;
  logic [31:0]         aux_rdata_r;
  logic                err_r;

  // Next-state, arbitration decision and timeout detection.
  always_comb begin
    state_next_s = state_r;
    grant_aux_s  = aux_req && (!cpu_req || (streak_r == STREAK_MAX));
    timeout_s    = (tmo_r == TMO_LAST) && !mem_ready;
    resp_data_s  = mem_ready ? mem_rdata : ERR_DATA;
    case (state_r)
      IDLE: begin
        if (cpu_req || aux_req) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready || timeout_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latching, counters, and registered completion pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r     <= OWN_CPU;
      streak_r    <= {STREAK_W{1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      cpu_ready_r <= 1'b0;
      aux_ready_r <= 1'b0;
      cpu_rdata_r <= 32'h0000_0000;
      aux_rdata_r <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else begin
      cpu_ready_r <= 1'b0;
      aux_ready_r <= 1'b0;
      err_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          tmo_r <= {TMO_W{1'b0}};
          if (cpu_req || aux_req) begin
            mem_req_r <= 1'b1;
            if (grant_aux_s) begin
              owner_r     <= OWN_AUX;
              mem_we_r    <= aux_we;
              mem_addr_r  <= aux_addr;
              mem_wdata_r <= aux_wdata;
              streak_r    <= {STREAK_W{1'b0}};
            end else begin
              owner_r     <= OWN_CPU;
              mem_we_r    <= cpu_we;
              mem_addr_r  <= cpu_addr;
              mem_wdata_r <= cpu_wdata;
              // Count CPU wins only while aux is actually waiting.
              if (!aux_req) begin
                streak_r <= {STREAK_W{1'b0}};
              end else if (streak_r != STREAK_MAX) begin
                streak_r <= streak_r + STREAK_W'(1);
              end
            end
          end
        end
        BUSY: begin
          if (mem_ready || timeout_s) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            tmo_r     <= {TMO_W{1'b0}};
            err_r     <= !mem_ready;
            if (owner_r == OWN_AUX) begin
              aux_ready_r <= 1'b1;
              aux_rdata_r <= resp_data_s;
            end else begin
              cpu_ready_r <= 1'b1;
              cpu_rdata_r <= resp_data_s;
            end
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        DONE: begin
          tmo_r <= {TMO_W{1'b0}};
        end
        default: begin
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          tmo_r     <= {TMO_W{1'b0}};
        end
      endcase
    end
  end

  assign cpu_ready = cpu_ready_r;
  assign cpu_rdata = cpu_rdata_r;
  assign aux_ready = aux_ready_r;
  assign aux_rdata = aux_rdata_r;
  assign err       = err_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single port of the data memory / SPI-mapped memory between two requesters: the pipeline memory stage (CPU) and an auxiliary master (boot/debug loader). It latches the winning request, holds it on the memory port until the memory's mem_ready completes it, then returns a registered ready/rdata pulse to the winner. CPU has fixed priority, with a starvation guard for the auxiliary master. A timeout aborts hung multi-cycle (SPI) accesses.

Parameters:
MAX_CPU_STREAK, 4, consecutive CPU grants allowed while aux_req is pending before aux is forced to win (1..15)
TIMEOUT_CYCLES, 256, cycles in BUSY without mem_ready before the access is aborted (>=2)
ERR_DATA, 32'hDEAD_BEEF, rdata returned on a timed-out access

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request; held until cpu_ready
cpu_we  input  1  CPU write enable (1=write, 0=read)
cpu_addr  input  32  CPU byte address
cpu_wdata  input  32  CPU write data
cpu_ready  output  1  one-cycle completion pulse to CPU
cpu_rdata  output  32  CPU read data, valid while cpu_ready=1
aux_req, aux_we, aux_addr[31:0], aux_wdata[31:0]  input  same meaning for aux master
aux_ready  output  1  one-cycle completion pulse to aux
aux_rdata  output  32  aux read data, valid while aux_ready=1
err  output  1  one-cycle pulse coincident with x_ready when the access timed out
mem_req  output  1  access active on memory port
mem_we  output  1  write enable to memory; never 1 while mem_req=0
mem_addr  output  32  latched address
mem_wdata  output  32  latched write data
mem_rdata  input  32  memory read data, sampled when mem_ready=1
mem_ready  input  1  memory completes current access this cycle

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; streak counter 0; timeout counter 0. Reset mid-access drops mem_req immediately; no ready pulse is issued for the aborted access.
- States: IDLE, BUSY, DONE. Owner register (CPU/AUX) is valid in BUSY and DONE.
- IDLE: if any req, arbitrate, latch we/addr/wdata of winner into mem_* registers, set owner, go BUSY. mem_req=1 from the next cycle. No req: stay IDLE.
- Arbitration: aux wins if aux_req and (cpu_req=0 or streak==MAX_CPU_STREAK); otherwise CPU wins. streak increments on a CPU grant while aux_req=1 (saturates at MAX_CPU_STREAK), and clears on an aux grant or when a CPU grant occurs with aux_req=0.
- BUSY: mem_req=1, mem_we=latched we. Requester inputs are ignored. Timeout counter increments each cycle.
  - On mem_ready=1: capture mem_rdata (writes capture it too; the value is don't-care), go DONE.
  - On counter reaching TIMEOUT_CYCLES-1 without mem_ready: load ERR_DATA, flag err, go DONE. If mem_ready arrives in that same cycle, mem_ready wins and err=0.
- DONE: mem_req=0. Owner's ready=1 for exactly one cycle, rdata=captured value, err per flag. The other ready stays 0. Requests sampled in DONE are ignored. Go IDLE and clear the timeout counter.
- Latency: request seen in IDLE in cycle 0; mem_req in cycle 1; mem_ready in cycle 1 gives ready in cycle 2. Minimum 3 cycles per access. A requester may present its next request in the cycle after ready; it is accepted in that cycle.
- cpu_rdata and aux_rdata hold their last value outside ready pulses.
- mem_addr and mem_wdata are stable for the whole BUSY period.

Decomposition:
- Package dmem_arb_pkg: state encoding (IDLE, BUSY, DONE), owner encoding (OWN_CPU, OWN_AUX), ERR_DATA default, counter widths derived from the parameters.
- Single module; no sub-module is warranted. The streak counter and the timeout counter are small and kept inline.

Test Plan:
- CPU read: cpu_req, cpu_addr=0x100, memory asserts mem_ready in the first BUSY cycle with mem_rdata=0x1234 -> mem_addr=0x100 in cycle 1, cpu_ready=1 and cpu_rdata=0x1234 in cycle 2, aux_ready=0, err=0.
- Simultaneous requests: cpu_req and aux_req both asserted in the same cycle (CPU addr 0x10, aux addr 0x20) -> CPU served first (mem_addr=0x10), then aux (mem_addr=0x20), each ready pulsed once.
- Starvation: MAX_CPU_STREAK=4, cpu_req held continuously, aux_req held -> exactly 4 CPU grants, then an aux grant, then CPU again.
- Timeout: TIMEOUT_CYCLES=16, mem_ready held 0 -> mem_req high for 16 cycles, then cpu_ready=1, err=1, cpu_rdata=0xDEADBEEF.
- Write plus multi-cycle memory: aux write, addr 0x40, data 0xCAFEF00D, mem_ready after 5 cycles -> mem_we=1 and mem_wdata stable for all 5 BUSY cycles, aux_ready 1 cycle later, mem_we=0 in DONE.
- Reset mid-BUSY: rst=0 during the third BUSY cycle -> mem_req=0 immediately, no ready pulse; after release, a new CPU read completes normally.
